// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage MIPS datapath (master) and pipe_hazard_ctrl (slave).
// The perf_* counters exist only when PIPE_HAZARD_CTRL_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic        ex_mem_read;
   logic        exmem_reg_write;
   logic [4:0]  exmem_write_reg;
   logic        memwb_reg_write;
   logic [4:0]  memwb_write_reg;
   logic        branch_taken;
   logic        mem_access;
   logic        mem_ready;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        pipe_en;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic        mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] perf_load_stalls;
   logic [31:0] perf_flush_cycles;
   logic [31:0] perf_mem_wait;
`endif

   modport slave (
      input  id_rs, id_rt, ex_rs, ex_rt, ex_mem_read,
      input  exmem_reg_write, exmem_write_reg, memwb_reg_write, memwb_write_reg,
      input  branch_taken, mem_access, mem_ready,
      output pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, fwd_a, fwd_b, mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      , output perf_load_stalls, perf_flush_cycles, perf_mem_wait
`endif
   );

   modport master (
      output id_rs, id_rt, ex_rs, ex_rt, ex_mem_read,
      output exmem_reg_write, exmem_write_reg, memwb_reg_write, memwb_write_reg,
      output branch_taken, mem_access, mem_ready,
      input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, fwd_a, fwd_b, mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      , input perf_load_stalls, perf_flush_cycles, perf_mem_wait
`endif
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, branch squashes, memory waits with timeout, and EX forwarding.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT  = 16,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_hazard_ctrl_if.slave hz
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);
   localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
   localparam logic [2:0]    FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_MEM_WAIT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d, wait_inc_s;
   logic [2:0]    flush_q, flush_d;
   logic          mem_err_q, mem_err_d;
   logic          mem_stall_s, load_use_s;
   logic          pc_en_s, ifid_en_s, pipe_en_s, ifid_flush_s, idex_flush_s;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic exw, input logic [4:0] exr,
                                          input logic mww, input logic [4:0] mwr);
      logic [1:0] sel;
      sel = 2'd0;
      if (exw && (exr != 5'd0) && (exr == src)) begin
         sel = 2'd2;
      end else if (mww && (mwr != 5'd0) && (mwr == src)) begin
         sel = 2'd1;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   assign mem_stall_s = hz.mem_access && !hz.mem_ready;
   assign load_use_s  = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                        ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));
   assign wait_inc_s  = (wait_q >= WAIT_MAX) ? wait_q : (wait_q + WAIT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         wait_q    <= '0;
         flush_q   <= 3'd0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         flush_q   <= flush_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Mealy next-state and pipeline controls; every path starts from a full freeze.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      flush_d      = flush_q;
      mem_err_d    = mem_err_q;
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      pipe_en_s    = 1'b0;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b0;
      case (state_q)
         ST_INIT: begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            state_d      = ST_RUN;
         end
         ST_RUN: begin
            if (mem_stall_s) begin
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_ONE;
            end else if (hz.branch_taken) begin
               {pc_en_s, ifid_en_s, pipe_en_s}  = 3'b111;
               {ifid_flush_s, idex_flush_s}     = 2'b11;
               if (FLUSH_CYCLES > 1) begin
                  state_d = ST_FLUSH;
                  flush_d = FLUSH_INIT;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (load_use_s) begin
               pipe_en_s    = 1'b1;
               idex_flush_s = 1'b1;
            end else begin
               {pc_en_s, ifid_en_s, pipe_en_s} = 3'b111;
            end
         end
         ST_FLUSH: begin
            if (mem_stall_s) begin
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_ONE;
            end else begin
               {pc_en_s, ifid_en_s, pipe_en_s} = 3'b111;
               {ifid_flush_s, idex_flush_s}    = 2'b11;
               if (flush_q <= 3'd1) begin
                  flush_d = 3'd0;
                  state_d = ST_RUN;
               end else begin
                  flush_d = flush_q - 3'd1;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (hz.mem_ready) begin
               {pc_en_s, ifid_en_s, pipe_en_s} = 3'b111;
               wait_d  = '0;
               state_d = (flush_q != 3'd0) ? ST_FLUSH : ST_RUN;
            end else if (wait_inc_s >= WAIT_MAX) begin
               // Forced release: the squash still owed to an earlier branch is dropped.
               {pc_en_s, ifid_en_s, pipe_en_s} = 3'b111;
               mem_err_d = 1'b1;
               wait_d    = '0;
               flush_d   = 3'd0;
               state_d   = ST_RUN;
            end else begin
               wait_d = wait_inc_s;
            end
         end
         default: begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            state_d      = ST_INIT;
         end
      endcase
   end

   assign hz.pc_en      = pc_en_s;
   assign hz.ifid_en    = ifid_en_s;
   assign hz.pipe_en    = pipe_en_s;
   assign hz.ifid_flush = ifid_flush_s;
   assign hz.idex_flush = idex_flush_s;
   assign hz.mem_err    = mem_err_q;
   assign hz.fwd_a = fwd_sel(hz.ex_rs, hz.exmem_reg_write, hz.exmem_write_reg,
                             hz.memwb_reg_write, hz.memwb_write_reg);
   assign hz.fwd_b = fwd_sel(hz.ex_rt, hz.exmem_reg_write, hz.exmem_write_reg,
                             hz.memwb_reg_write, hz.memwb_write_reg);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] perf_load_q, perf_flush_q, perf_mem_q;

   // Event counters wrap modulo 2^32; a load stall is the only state with pipe_en high and pc_en low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_load_q  <= 32'd0;
         perf_flush_q <= 32'd0;
         perf_mem_q   <= 32'd0;
      end else begin
         perf_load_q  <= perf_load_q + {31'd0, ((state_q == ST_RUN) && !pc_en_s && pipe_en_s)};
         perf_flush_q <= perf_flush_q + {31'd0, ((state_q != ST_INIT) && ifid_flush_s)};
         perf_mem_q   <= perf_mem_q + {31'd0, ((state_q != ST_INIT) && !pc_en_s && !pipe_en_s)};
      end
   end

   assign hz.perf_load_stalls  = perf_load_q;
   assign hz.perf_flush_cycles = perf_flush_q;
   assign hz.perf_mem_wait     = perf_mem_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan scenarios followed by random traffic.
module tb_pipe_hazard_ctrl;
   localparam int MEM_TIMEOUT  = 16;
   localparam int FLUSH_CYCLES = 2;

   typedef struct packed {
      logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
      logic       ex_mem_read;
      logic       exmem_reg_write;
      logic [4:0] exmem_write_reg;
      logic       memwb_reg_write;
      logic [4:0] memwb_write_reg;
      logic       branch_taken, mem_access, mem_ready;
   } in_t;

   typedef struct packed {
      logic       pc_en, ifid_en, ifid_flush, idex_flush, pipe_en;
      logic [1:0] fwd_a, fwd_b;
      logic       mem_err;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb_q[$];

   // Reference model: cycles left to squash, cycles spent waiting, sticky error.
   bit   m_init;
   bit   m_waiting;
   int   m_wait_cnt;
   int   m_flush_left;
   bit   m_err;

   pipe_hazard_ctrl_if hz();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] fwd_model(input logic [4:0] r, input in_t x);
      if (r == 5'd0) return 2'd0;
      if (x.exmem_reg_write && x.exmem_write_reg == r) return 2'd2;
      if (x.memwb_reg_write && x.memwb_write_reg == r) return 2'd1;
      return 2'd0;
   endfunction

   task automatic model_step(input logic rst_v, input in_t x);
      exp_t e;
      bit   hazard;
      e = '0;
      e.fwd_a   = fwd_model(x.ex_rs, x);
      e.fwd_b   = fwd_model(x.ex_rt, x);
      e.mem_err = m_err;
      hazard = x.ex_mem_read && x.ex_rt != 5'd0 && (x.ex_rt == x.id_rs || x.ex_rt == x.id_rt);
      if (!rst_v) begin
         e.ifid_flush = 1'b1; e.idex_flush = 1'b1; e.mem_err = 1'b0;
         m_init = 1'b1; m_waiting = 1'b0; m_wait_cnt = 0; m_flush_left = 0; m_err = 1'b0;
      end else if (m_init) begin
         e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
         m_init = 1'b0;
      end else if (m_waiting) begin
         m_wait_cnt++;
         if (x.mem_ready) begin
            {e.pc_en, e.ifid_en, e.pipe_en} = 3'b111;
            m_waiting = 1'b0;
         end else if (m_wait_cnt >= MEM_TIMEOUT) begin
            {e.pc_en, e.ifid_en, e.pipe_en} = 3'b111;
            m_waiting = 1'b0; m_err = 1'b1; m_flush_left = 0;
         end
      end else if (x.mem_access && !x.mem_ready) begin
         m_waiting = 1'b1; m_wait_cnt = 1;
      end else if (m_flush_left > 0) begin
         {e.pc_en, e.ifid_en, e.pipe_en, e.ifid_flush, e.idex_flush} = 5'b11111;
         m_flush_left--;
      end else if (x.branch_taken) begin
         {e.pc_en, e.ifid_en, e.pipe_en, e.ifid_flush, e.idex_flush} = 5'b11111;
         m_flush_left = FLUSH_CYCLES - 1;
      end else if (hazard) begin
         e.pipe_en = 1'b1; e.idex_flush = 1'b1;
      end else begin
         {e.pc_en, e.ifid_en, e.pipe_en} = 3'b111;
      end
      sb_q.push_back(e);
   endtask

   task automatic tick(input logic rst_v, input in_t x);
      @(posedge clk);
      #2;
      rst_n              = rst_v;
      hz.id_rs           = x.id_rs;
      hz.id_rt           = x.id_rt;
      hz.ex_rs           = x.ex_rs;
      hz.ex_rt           = x.ex_rt;
      hz.ex_mem_read     = x.ex_mem_read;
      hz.exmem_reg_write = x.exmem_reg_write;
      hz.exmem_write_reg = x.exmem_write_reg;
      hz.memwb_reg_write = x.memwb_reg_write;
      hz.memwb_write_reg = x.memwb_write_reg;
      hz.branch_taken    = x.branch_taken;
      hz.mem_access      = x.mem_access;
      hz.mem_ready       = x.mem_ready;
      model_step(rst_v, x);
   endtask

   function automatic in_t rand_in();
      in_t x;
      x.id_rs           = 5'($urandom_range(0, 3));
      x.id_rt           = 5'($urandom_range(0, 3));
      x.ex_rs           = 5'($urandom_range(0, 3));
      x.ex_rt           = 5'($urandom_range(0, 3));
      x.ex_mem_read     = ($urandom_range(0, 2) == 0);
      x.exmem_reg_write = 1'($urandom_range(0, 1));
      x.exmem_write_reg = 5'($urandom_range(0, 3));
      x.memwb_reg_write = 1'($urandom_range(0, 1));
      x.memwb_write_reg = 5'($urandom_range(0, 3));
      x.branch_taken    = ($urandom_range(0, 5) == 0);
      x.mem_access      = ($urandom_range(0, 4) == 0);
      x.mem_ready       = ($urandom_range(0, 2) == 0);
      return x;
   endfunction

   // Monitor: one scoreboard entry is due on every falling edge after the driver has issued it.
   always @(negedge clk) begin
      exp_t act;
      exp_t want;
      if (sb_q.size() > 0) begin
         want = sb_q.pop_front();
         act  = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_flush, hz.pipe_en,
                 hz.fwd_a, hz.fwd_b, hz.mem_err};
         checks++;
         if (act !== want) begin
            errors++;
            $display("FAIL outputs t=%0t got %b want %b (pc_en,ifid_en,ifid_flush,idex_flush,pipe_en,fwd_a,fwd_b,mem_err)",
                     $time, act, want);
         end
      end
   end

   initial begin
      in_t x;
      checks = 0;
      errors = 0;
      m_init = 1'b1; m_waiting = 1'b0; m_wait_cnt = 0; m_flush_left = 0; m_err = 1'b0;
      x = '0;
      rst_n = 1'b0;
      hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.ex_rs = 5'd0; hz.ex_rt = 5'd0;
      hz.ex_mem_read = 1'b0; hz.exmem_reg_write = 1'b0; hz.exmem_write_reg = 5'd0;
      hz.memwb_reg_write = 1'b0; hz.memwb_write_reg = 5'd0;
      hz.branch_taken = 1'b0; hz.mem_access = 1'b0; hz.mem_ready = 1'b0;

      // Reset, release, INIT then RUN.
      tick(1'b0, x); tick(1'b0, x);
      tick(1'b1, x); tick(1'b1, x); tick(1'b1, x);

      // Load-use on rs, then the load advances; ex_rt = 0 never stalls.
      x = '0; x.ex_mem_read = 1'b1; x.ex_rt = 5'd5; x.id_rs = 5'd5;
      tick(1'b1, x);
      x = '0; tick(1'b1, x);
      x.ex_mem_read = 1'b1; x.ex_rt = 5'd0; x.id_rs = 5'd0;
      tick(1'b1, x);

      // Forwarding priority and register 0.
      x = '0; x.ex_rs = 5'd3; x.exmem_reg_write = 1'b1; x.exmem_write_reg = 5'd3;
      x.memwb_reg_write = 1'b1; x.memwb_write_reg = 5'd3;
      tick(1'b1, x);
      x.exmem_reg_write = 1'b0; tick(1'b1, x);
      x.ex_rs = 5'd0; x.exmem_reg_write = 1'b1; x.exmem_write_reg = 5'd0; x.memwb_write_reg = 5'd0;
      tick(1'b1, x);

      // Branch coinciding with load-use: two squash cycles, no stall.
      x = '0; x.branch_taken = 1'b1; x.ex_mem_read = 1'b1; x.ex_rt = 5'd7; x.id_rt = 5'd7;
      tick(1'b1, x);
      x.branch_taken = 1'b0; tick(1'b1, x);
      x = '0; tick(1'b1, x);

      // Three frozen cycles, then ready.
      x = '0; x.mem_access = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b1, x);
      x.mem_ready = 1'b1; tick(1'b1, x);
      x = '0; tick(1'b1, x);

      // Timeout: forced release on the 16th wait cycle, sticky error, then reset mid-wait.
      x = '0; x.mem_access = 1'b1;
      for (int i = 0; i < 20; i++) tick(1'b1, x);
      x = '0;
      for (int i = 0; i < 3; i++) tick(1'b1, x);
      x.mem_access = 1'b1; tick(1'b1, x); tick(1'b1, x);
      tick(1'b0, x);
      x = '0; tick(1'b1, x); tick(1'b1, x);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 299) != 0), rand_in());
      end
      x = '0; tick(1'b1, x);

      // Drain: bounded wait for the monitor to consume every issued entry.
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
